// File: rtl/avl_pkg.sv
// Shared types and burst-length helpers for the Avalon-MM SRAM slave.
package avl_pkg;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StRdBurst = 2'd1,
      StWrBurst = 2'd2
   } avl_state_e;

   function automatic int unsigned bc_width(input int unsigned max_burst);
      return $clog2(max_burst) + 1;
   endfunction

   // A zero count still moves one beat; oversize counts saturate.
   function automatic int unsigned clamp_burst(input int unsigned count,
                                               input int unsigned max_burst);
      if (count == 0) return 1;
      if (count > max_burst) return max_burst;
      return count;
   endfunction

endpackage

// File: rtl/avl_sram_bytes.sv
// Single-port synchronous SRAM, 32-bit words, per-byte write enables, 1-cycle read latency.
module avl_sram_bytes #(
   parameter int unsigned DEPTH = 2048,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          i_clk,
   input  logic          i_en,
   input  logic          i_we,
   input  logic [3:0]    i_be,
   input  logic [AW-1:0] i_addr,
   input  logic [31:0]   i_wdata,
   output logic [31:0]   o_rdata
);

   logic [31:0] r_mem [DEPTH];
   logic [31:0] r_rdata;

   always_ff @(posedge i_clk) begin
      if (i_en) begin
         if (i_we) begin
            for (int unsigned b = 0; b < 4; b++) begin
               if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
         end else begin
            r_rdata <= r_mem[i_addr];
         end
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/avl_sram_slave.sv
// Avalon-MM burst slave in front of a byte-enabled SRAM: wait states, burst
// sequencing and pipelined read-data return. DATA_WIDTH is expected to be 32.
module avl_sram_slave
   import avl_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned MEM_BYTES   = 8192,
   parameter int unsigned MAX_BURST   = 16,
   parameter int unsigned WAIT_CYCLES = 0,
   localparam int unsigned BC_W       = bc_width(MAX_BURST)
) (
   input  logic                    i_clk,
   input  logic                    i_rest,
   input  logic [ADDR_WIDTH-1:0]   i_avl_s_address,
   input  logic [DATA_WIDTH/8-1:0] i_avl_s_byte_en,
   input  logic                    i_avl_s_read,
   input  logic                    i_avl_s_write,
   input  logic [DATA_WIDTH-1:0]   i_avl_s_write_data,
   input  logic [BC_W-1:0]         i_avl_s_burst_count,
   output logic [DATA_WIDTH-1:0]   o_avl_s_read_data,
   output logic                    o_avl_s_read_data_valid,
   output logic                    o_avl_s_wait_request
);

   localparam int unsigned WORDS = MEM_BYTES / 4;
   localparam int unsigned AW    = $clog2(WORDS);
   localparam int unsigned MB    = $clog2(MEM_BYTES);
   localparam int unsigned WC_W  = $clog2(WAIT_CYCLES + 2);

   avl_state_e      r_state, w_state_d;
   logic [AW-1:0]   r_addr, w_addr_d;
   logic [BC_W-1:0] r_left, w_left_d;
   logic [WC_W-1:0] r_wait, w_wait_d;
   logic            r_rd_valid;

   logic            w_cmd;
   logic            w_wait_core;
   logic            w_ram_en;
   logic            w_ram_we;
   logic            w_rd_issue;
   logic [AW-1:0]   w_ram_addr;
   logic [AW-1:0]   w_cmd_word;
   logic [BC_W-1:0] w_len;
   logic [31:0]     w_ram_q;
   logic            w_unused_addr;

   assign w_cmd         = i_avl_s_read | i_avl_s_write;
   assign w_cmd_word    = i_avl_s_address[MB-1:2];
   assign w_len         = BC_W'(clamp_burst(32'(i_avl_s_burst_count), MAX_BURST));
   assign w_unused_addr = ^{i_avl_s_address[ADDR_WIDTH-1:MB], i_avl_s_address[1:0]};

   always_comb begin
      w_state_d   = r_state;
      w_addr_d    = r_addr;
      w_left_d    = r_left;
      w_wait_d    = r_wait;
      w_wait_core = 1'b1;
      w_ram_en    = 1'b0;
      w_ram_we    = 1'b0;
      w_rd_issue  = 1'b0;
      w_ram_addr  = r_addr;
      unique case (r_state)
         StIdle: begin
            w_wait_core = (r_wait != WC_W'(WAIT_CYCLES));
            w_ram_addr  = w_cmd_word;
            if (w_cmd) begin
               if (w_wait_core) begin
                  w_wait_d = r_wait + WC_W'(1);
               end else begin
                  // Beat 1 goes to the SRAM in the accept cycle; write wins over read.
                  w_wait_d = '0;
                  w_ram_en = 1'b1;
                  w_addr_d = w_cmd_word + AW'(1);
                  w_left_d = w_len - BC_W'(1);
                  if (i_avl_s_write) begin
                     w_ram_we = 1'b1;
                     if (w_len > BC_W'(1)) w_state_d = StWrBurst;
                  end else begin
                     w_rd_issue = 1'b1;
                     if (w_len > BC_W'(1)) w_state_d = StRdBurst;
                  end
               end
            end
         end
         StRdBurst: begin
            w_ram_en   = 1'b1;
            w_rd_issue = 1'b1;
            w_addr_d   = r_addr + AW'(1);
            w_left_d   = r_left - BC_W'(1);
            if (r_left == BC_W'(1)) w_state_d = StIdle;
         end
         StWrBurst: begin
            w_wait_core = 1'b0;
            if (i_avl_s_write) begin
               w_ram_en = 1'b1;
               w_ram_we = 1'b1;
               w_addr_d = r_addr + AW'(1);
               w_left_d = r_left - BC_W'(1);
               if (r_left == BC_W'(1)) w_state_d = StIdle;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rest) begin
      if (!i_rest) begin
         r_state    <= StIdle;
         r_addr     <= '0;
         r_left     <= '0;
         r_wait     <= '0;
         r_rd_valid <= 1'b0;
      end else begin
         r_state    <= w_state_d;
         r_addr     <= w_addr_d;
         r_left     <= w_left_d;
         r_wait     <= w_wait_d;
         r_rd_valid <= w_rd_issue;
      end
   end

   avl_sram_bytes #(
      .DEPTH (WORDS),
      .AW    (AW)
   ) u_ram (
      .i_clk   (i_clk),
      .i_en    (w_ram_en),
      .i_we    (w_ram_we),
      .i_be    (i_avl_s_byte_en),
      .i_addr  (w_ram_addr),
      .i_wdata (i_avl_s_write_data),
      .o_rdata (w_ram_q)
   );

   // Reset is folded in combinationally so the stall shows while rest is low.
   assign o_avl_s_wait_request    = w_wait_core | ~i_rest;
   assign o_avl_s_read_data_valid = r_rd_valid;
   assign o_avl_s_read_data       = r_rd_valid ? w_ram_q : '0;

   a_rd_wr_idle: assert property (@(posedge i_clk) disable iff (!i_rest)
      !(r_state == StIdle && i_avl_s_read && i_avl_s_write));
   a_rd_in_wr_burst: assert property (@(posedge i_clk) disable iff (!i_rest)
      !(r_state == StWrBurst && i_avl_s_read));

endmodule

// File: tb/tb_avl_sram_slave.sv
// Self-checking bench: word-array memory model plus expected-beat queue with due cycles.
module tb_avl_sram_slave;

   localparam int MEM_BYTES = 8192;
   localparam int WORDS     = MEM_BYTES / 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] a_addr, a_wd, a_rdata;
   logic [3:0]  a_be;
   logic [4:0]  a_bc;
   logic        a_rd, a_wr, a_rvalid, a_wreq;

   logic [31:0] b_addr, b_wd, b_rdata;
   logic [3:0]  b_be;
   logic [4:0]  b_bc;
   logic        b_rd, b_wr, b_rvalid, b_wreq;

   avl_sram_slave u_dut (
      .i_clk                   (clk),
      .i_rest                  (rst_n),
      .i_avl_s_address         (a_addr),
      .i_avl_s_byte_en         (a_be),
      .i_avl_s_read            (a_rd),
      .i_avl_s_write           (a_wr),
      .i_avl_s_write_data      (a_wd),
      .i_avl_s_burst_count     (a_bc),
      .o_avl_s_read_data       (a_rdata),
      .o_avl_s_read_data_valid (a_rvalid),
      .o_avl_s_wait_request    (a_wreq)
   );

   avl_sram_slave #(.WAIT_CYCLES(2)) u_dut_ws (
      .i_clk                   (clk),
      .i_rest                  (rst_n),
      .i_avl_s_address         (b_addr),
      .i_avl_s_byte_en         (b_be),
      .i_avl_s_read            (b_rd),
      .i_avl_s_write           (b_wr),
      .i_avl_s_write_data      (b_wd),
      .i_avl_s_burst_count     (b_bc),
      .o_avl_s_read_data       (b_rdata),
      .o_avl_s_read_data_valid (b_rvalid),
      .o_avl_s_wait_request    (b_wreq)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [31:0] mem_m [WORDS];
   logic [31:0] wbuf [16];

   typedef struct {
      logic [31:0] d;
      int          due;
   } exp_t;
   exp_t expq[$];
   exp_t mon_e;
   bit   mon_en = 1'b1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   function automatic int beats(input int bc);
      if (bc == 0) return 1;
      if (bc > 16) return 16;
      return bc;
   endfunction

   function automatic int widx(input logic [31:0] a, input int k);
      return (int'(a[12:2]) + k) % WORDS;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = o;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
      return r;
   endfunction

   // Every read beat must arrive exactly on its due cycle, in order, with no extras.
   always @(negedge clk) begin
      if (mon_en) begin
         if (a_rvalid) begin
            if (expq.size() == 0) begin
               total++; bad++;
               $display("FAIL rd_extra: valid at cycle %0d data %h, required no beat", cyc, a_rdata);
            end else begin
               mon_e = expq.pop_front();
               chk("rd_data", a_rdata, mon_e.d);
               chk("rd_cycle", 32'(cyc), 32'(mon_e.due));
            end
         end else if (expq.size() > 0 && expq[0].due <= cyc) begin
            mon_e = expq.pop_front();
            total++; bad++;
            $display("FAIL rd_missing: no valid at cycle %0d, required beat %h", cyc, mon_e.d);
         end
      end
   end

   task automatic wait_accept(output bit ok, output int acc, output int nwait);
      ok = 1'b0; acc = 0; nwait = 0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (!a_wreq) begin ok = 1'b1; acc = cyc; break; end
         nwait++;
      end
      if (!ok) begin
         total++; bad++;
         $display("FAIL accept_timeout: wait_request high 64 cycles, required low");
      end
      @(posedge clk); #1;
   endtask

   task automatic rd(input logic [31:0] addr, input int bc, input bit chk_wait,
                     input bit use_exp, input logic [31:0] exp_d, output int nwait);
      bit ok;
      int acc, n, hi;
      a_addr = addr; a_bc = bc[4:0]; a_rd = 1'b1; a_wr = 1'b0;
      wait_accept(ok, acc, nwait);
      a_rd = 1'b0; a_addr = $urandom;
      if (ok) begin
         n = beats(bc);
         for (int k = 0; k < n; k++)
            expq.push_back('{d: (use_exp ? exp_d : mem_m[widx(addr, k)]), due: acc + 1 + k});
         if (chk_wait) begin
            hi = 0;
            for (int i = 0; i < 40; i++) begin
               @(negedge clk);
               if (a_wreq) hi++; else break;
            end
            chk("rd_burst_wait_cycles", 32'(hi), 32'(n - 1));
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic wr(input logic [31:0] addr, input int bc, input logic [3:0] be_v,
                     input int stall_at, input int stall_n);
      bit ok;
      int acc, nw, n;
      n = beats(bc);
      a_addr = addr; a_bc = bc[4:0]; a_be = be_v; a_wd = wbuf[0]; a_wr = 1'b1; a_rd = 1'b0;
      wait_accept(ok, acc, nw);
      if (!ok) begin a_wr = 1'b0; return; end
      mem_m[widx(addr, 0)] = merge(mem_m[widx(addr, 0)], wbuf[0], be_v);
      for (int k = 1; k < n; k++) begin
         if (k == stall_at) begin
            a_wr = 1'b0; a_wd = $urandom;
            repeat (stall_n) begin @(posedge clk); #1; end
         end
         a_wr = 1'b1; a_wd = wbuf[k]; a_addr = $urandom; a_bc = 5'($urandom);
         @(negedge clk);
         chk("wr_beat_wait", 32'(a_wreq), 32'd0);
         @(posedge clk); #1;
         mem_m[widx(addr, k)] = merge(mem_m[widx(addr, k)], wbuf[k], be_v);
      end
      a_wr = 1'b0;
   endtask

   typedef struct {
      logic [31:0] waddr;
      logic [31:0] raddr;
      logic [31:0] pre;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] exp_d;
   } vec_t;
   vec_t tbl [6];

   initial begin
      int nw, n, op;
      logic [31:0] ra;
      a_addr = '0; a_wd = '0; a_be = '0; a_bc = '0; a_rd = 1'b0; a_wr = 1'b0;
      b_addr = '0; b_wd = '0; b_be = '0; b_bc = '0; b_rd = 1'b0; b_wr = 1'b0;

      tbl[0] = '{32'h100,   32'h100, 32'h0000_0000, 32'hDEAD_BEEF, 4'hF,    32'hDEAD_BEEF};
      tbl[1] = '{32'h200,   32'h200, 32'h1122_3344, 32'h0000_AB00, 4'b0010, 32'h1122_AB44};
      tbl[2] = '{32'h204,   32'h204, 32'hFFFF_FFFF, 32'h1234_5678, 4'b0101, 32'hFF34_FF78};
      tbl[3] = '{32'h208,   32'h208, 32'hAAAA_AAAA, 32'h5555_5555, 4'b1000, 32'h55AA_AAAA};
      tbl[4] = '{32'h20C,   32'h20C, 32'h0102_0304, 32'hFFFF_FFFF, 4'b0000, 32'h0102_0304};
      tbl[5] = '{32'h12210, 32'h210, 32'h0000_0000, 32'hCAFE_F00D, 4'hF,    32'hCAFE_F00D};

      #2;
      chk("rst_valid", 32'(a_rvalid), 32'd0);
      chk("rst_rdata", a_rdata, 32'd0);
      chk("rst_wait", 32'(a_wreq), 32'd1);
      chk("rst_wait_ws", 32'(b_wreq), 32'd1);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      for (int blk = 0; blk < WORDS / 16; blk++) begin
         for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
         wr(32'(blk * 64), 16, 4'hF, -1, 0);
      end

      foreach (tbl[t]) begin
         wbuf[0] = tbl[t].pre;
         wr(tbl[t].waddr, 1, 4'hF, -1, 0);
         wbuf[0] = tbl[t].wdata;
         wr(tbl[t].waddr, 1, tbl[t].be, -1, 0);
         rd(tbl[t].raddr, 1, 1'b0, 1'b1, tbl[t].exp_d, nw);
      end

      // 16-beat line fill of an index pattern
      for (int i = 0; i < 16; i++) wbuf[i] = 32'(i);
      wr(32'h40, 16, 4'hF, -1, 0);
      rd(32'h40, 16, 1'b1, 1'b0, '0, nw);

      // Stalled write burst, sentinel right after it must survive
      wbuf[0] = 32'h5E5E_5E5E;
      wr(32'h90, 1, 4'hF, -1, 0);
      for (int i = 0; i < 4; i++) wbuf[i] = 32'hB000_0001 + 32'(i);
      wr(32'h80, 4, 4'hF, 2, 2);
      rd(32'h80, 5, 1'b0, 1'b0, '0, nw);
      chk("idle_after_wr_burst", 32'(nw), 32'd0);

      rd(32'h100, 0, 1'b1, 1'b0, '0, nw);
      rd(32'h140, 31, 1'b1, 1'b0, '0, nw);

      // Two wait states on the second instance
      b_addr = 32'h10; b_wd = 32'hA5A5_5A5A; b_be = 4'hF; b_bc = 5'd1; b_wr = 1'b1;
      n = 0;
      for (int i = 0; i < 10; i++) begin @(negedge clk); if (b_wreq) n++; else break; end
      chk("ws_wr_wait", 32'(n), 32'd2);
      @(posedge clk); #1;
      b_wr = 1'b0; b_rd = 1'b1;
      n = 0;
      for (int i = 0; i < 10; i++) begin @(negedge clk); if (b_wreq) n++; else break; end
      chk("ws_rd_wait", 32'(n), 32'd2);
      @(posedge clk); #1;
      b_rd = 1'b0;
      @(negedge clk);
      chk("ws_valid", 32'(b_rvalid), 32'd1);
      chk("ws_data", b_rdata, 32'hA5A5_5A5A);
      @(negedge clk);
      chk("ws_valid_end", 32'(b_rvalid), 32'd0);
      @(posedge clk); #1;

      // Wrap at the top of memory
      for (int i = 0; i < 4; i++) wbuf[i] = $urandom;
      wr(32'(MEM_BYTES - 8), 4, 4'hF, -1, 0);
      rd(32'(MEM_BYTES - 8), 4, 1'b1, 1'b0, '0, nw);

      // Reset in the middle of a read burst
      rd(32'h40, 8, 1'b0, 1'b0, '0, nw);
      @(negedge clk);
      @(negedge clk);
      chk("valid_before_reset", 32'(a_rvalid), 32'd1);
      #1 mon_en = 1'b0; expq.delete();
      #1 rst_n = 1'b0;
      #1;
      chk("reset_valid_drop", 32'(a_rvalid), 32'd0);
      chk("reset_rdata_zero", a_rdata, 32'd0);
      chk("reset_wait_high", 32'(a_wreq), 32'd1);
      repeat (2) begin
         @(negedge clk);
         chk("reset_wait_hold", 32'(a_wreq), 32'd1);
      end
      rst_n = 1'b1; mon_en = 1'b1;
      @(posedge clk); #1;
      rd(32'h44, 1, 1'b0, 1'b0, '0, nw);
      chk("post_reset_no_wait", 32'(nw), 32'd0);

      for (int r = 0; r < 60; r++) begin
         op = $urandom_range(0, 2);
         ra = $urandom & 32'h0001_FFFF;
         if (op == 0) begin
            for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
            wr(ra, $urandom_range(0, 31), 4'($urandom), $urandom_range(1, 16),
               $urandom_range(0, 3));
         end else begin
            rd(ra, $urandom_range(0, 31), 1'b0, 1'b0, '0, nw);
         end
      end

      for (int i = 0; i < 100 && expq.size() > 0; i++) @(posedge clk);
      @(negedge clk);
      chk("rd_queue_drained", 32'(expq.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/avl_sram_slave.md
Name: avl_sram_slave

Overview:
- Avalon-MM slave responder on the far end of the CPU's `i_avl_bus` masters: the memory buses and the cache line-fill path.
- Fronts a byte-enabled on-chip synchronous SRAM.
- Supports single and burst reads and writes, a configurable number of pre-accept wait states, and pipelined read-data return.
- Sized to serve 64-byte cache line fills (16 beats at 32 bits).

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, data width; must be 32.
- MEM_BYTES, 8192, memory size in bytes; power of two.
- MAX_BURST, 16, maximum beats per burst.
- WAIT_CYCLES, 0, wait_request cycles inserted before each command is accepted.
- Derived localparam BC_W = $clog2(MAX_BURST)+1.

Ports:
- clk  in  1  clock
- rest  in  1  asynchronous reset, active low
- avl_s_address  in  ADDR_WIDTH  byte address; bits [1:0] ignored
- avl_s_byte_en  in  DATA_WIDTH/8  write byte enables
- avl_s_read  in  1  read request
- avl_s_write  in  1  write request/beat
- avl_s_write_data  in  DATA_WIDTH  write data
- avl_s_burst_count  in  BC_W  beats; sampled on the first beat only
- avl_s_read_data  out  DATA_WIDTH  read data
- avl_s_read_data_valid  out  1  read beat valid
- avl_s_wait_request  out  1  stall; a command or beat is accepted when (read|write) && !wait_request

Behaviour:
Reset:
- rest low forces read_data=0, read_data_valid=0, wait_request=1, FSM=IDLE, counters=0.
- SRAM contents are not reset.
- Reset mid-burst aborts the burst; valid drops in the same cycle as rest falls.

Addressing:
- Word index = address[$clog2(MEM_BYTES)-1:2]; upper bits alias.
- Burst address increments by one word per beat and wraps modulo MEM_BYTES.

Burst count:
- 0 is treated as 1; values above MAX_BURST are clamped to MAX_BURST.

Wait states:
- In IDLE with read|write high, wait_request stays high for WAIT_CYCLES cycles (wait counter), then low.
- The command is accepted on that low cycle; the counter clears on acceptance.
- WAIT_CYCLES=0: wait_request is low in IDLE combinationally.

FSM states:
- IDLE
- RD_BURST
- WR_BURST

Read:
- On acceptance in cycle N, beat 1 is issued to the SRAM in cycle N.
- If len>1, go to RD_BURST: issue beats 2..len on consecutive cycles with wait_request=1, then return to IDLE.
- read_data_valid is high exactly on cycles N+1 .. N+len, with no gaps.
- A new command may be accepted in IDLE while trailing beats are still returning.

Write:
- First beat accepted in IDLE writes word 1 with byte_en; if len>1, go to WR_BURST.
- In WR_BURST, wait_request=0; each cycle with write=1 commits the next beat.
- write=0 stalls the burst with no state change.
- After beat len, return to IDLE.
- Address and burst_count are ignored on non-first beats.

Ordering:
- A write commits at the clock edge ending its accept cycle.
- A read accepted in the next cycle returns the new data; no bypass is needed.

Simultaneous events:
- read and write both high in IDLE: write is serviced; read is dropped (protocol violation, SVA flags it).
- read high in WR_BURST: ignored (SVA flags it).

Decomposition:
Package avl_pkg:
- avl_state_e (IDLE, RD_BURST, WR_BURST).
- Function bc_width(max_burst).
- Function clamp_burst(count, max) implementing the 0→1 and >MAX clamp rules.

Sub-module avl_sram_bytes:
- Single-port synchronous RAM, 1-cycle read latency, per-byte write enable, depth MEM_BYTES/4.
- Top-level holds the FSM, wait counter, beat counter, address incrementer and valid pipeline.

Test Plan:
1. Write 0x100 = 0xDEADBEEF, be=4'hF, then single read 0x100 → valid exactly 1 cycle after accept; data 0xDEADBEEF.
2. Preload 0x200 = 0x11223344; write 0x0000AB00 with be=4'b0010; read 0x200 → 0x1122AB44.
3. Fill 0x40..0x7C with index pattern; read burst_count=16 at 0x40 → 16 consecutive valids 0..15; wait_request high 15 cycles after accept.
4. Write burst_count=4 at 0x80; master drops write for 2 cycles before beat 3 → 0x80..0x8C hold beats 1..4; no extra writes; FSM back in IDLE after beat 4.
5. WAIT_CYCLES=2; single read → wait_request high 2 cycles, accepted on 3rd, valid on 4th. Separately, burst_count=0 and burst_count=31 → 1 beat and 16 beats respectively.
6. Burst of 4 starting at MEM_BYTES-8 → beats from MEM_BYTES-8, MEM_BYTES-4, 0x0, 0x4. Then assert rest low mid-burst after beat 2 → valid low immediately, wait_request=1 during reset; a subsequent single read is served normally.
